// File: rtl/ram_stream_reader_if.sv
// ============================================================================
//  ram_stream_reader_if : control, RAM read port and output stream bundle
//  Rev 1.0
// ============================================================================
`default_nettype none

interface ram_stream_reader_if #(
   parameter int width_p = 8,
   parameter int depth_p = 512
);
   localparam int AW = $clog2(depth_p);

   logic               start_i;
   logic [AW-1:0]      base_addr_i;
   logic [AW:0]        count_i;
   logic               busy_o;
   logic               done_o;
   logic               rd_valid_o;
   logic [AW-1:0]      rd_addr_o;
   logic [width_p-1:0] rd_data_i;
   logic               valid_o;
   logic [width_p-1:0] data_o;
   logic               ready_i;

   modport master (
      input  start_i, base_addr_i, count_i, rd_data_i, ready_i,
      output busy_o, done_o, rd_valid_o, rd_addr_o, valid_o, data_o
   );

   modport slave (
      output start_i, base_addr_i, count_i, rd_data_i, ready_i,
      input  busy_o, done_o, rd_valid_o, rd_addr_o, valid_o, data_o
   );
endinterface

`default_nettype wire

// File: rtl/ram_stream_reader.sv
// ============================================================================
//  ram_stream_reader : burst reader from a 1-cycle-latency RAM onto a
//  valid/ready stream through a 2-entry buffer.   Rev 1.0
// ============================================================================
`default_nettype none

module ram_stream_reader #(
   parameter int width_p = 8,
   parameter int depth_p = 512
) (
   input  wire logic             clk_i,
   input  wire logic             reset_n_i,
   ram_stream_reader_if.master   bus
);
   localparam int AW = $clog2(depth_p);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_READ  = 2'd1,
      ST_DRAIN = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic [AW-1:0]      addr_q, addr_d;
   logic [AW:0]        remain_q, remain_d;
   logic               inflight_q, inflight_d;
   logic [1:0]         cnt_q, cnt_d;
   logic               wr_ptr_q, wr_ptr_d;
   logic               rd_ptr_q, rd_ptr_d;
   logic               done_q, done_d;
   logic [width_p-1:0] buf_q [0:1];

   logic               pop;
   logic               issue;
   logic [1:0]         occ;

   always_ff @(posedge clk_i) begin
      if (!reset_n_i) begin
         state_q    <= ST_IDLE;
         addr_q     <= '0;
         remain_q   <= '0;
         inflight_q <= 1'b0;
         cnt_q      <= '0;
         wr_ptr_q   <= 1'b0;
         rd_ptr_q   <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         addr_q     <= addr_d;
         remain_q   <= remain_d;
         inflight_q <= inflight_d;
         cnt_q      <= cnt_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         done_q     <= done_d;
      end
   end

   // RAM data lands in the buffer the cycle after its read was issued.
   always_ff @(posedge clk_i) begin
      if (!reset_n_i) begin
         buf_q[0] <= '0;
         buf_q[1] <= '0;
      end else if (inflight_q) begin
         buf_q[wr_ptr_q] <= bus.rd_data_i;
      end
   end

   always_comb begin
      pop   = (cnt_q != 2'd0) && bus.ready_i;
      // Occupancy after this edge, before any new read: buffered + in flight - popped.
      occ   = cnt_q + {1'b0, inflight_q} - {1'b0, pop};
      issue = (state_q == ST_READ) && (remain_q != '0) && (occ < 2'd2);

      state_d    = state_q;
      addr_d     = addr_q;
      remain_d   = remain_q;
      inflight_d = issue;
      cnt_d      = occ;
      wr_ptr_d   = wr_ptr_q ^ inflight_q;
      rd_ptr_d   = rd_ptr_q ^ pop;
      done_d     = 1'b0;

      if (issue) begin
         addr_d   = (addr_q == AW'(depth_p - 1)) ? '0 : addr_q + AW'(1);
         remain_d = remain_q - (AW+1)'(1);
      end

      case (state_q)
         ST_IDLE: begin
            if (bus.start_i) begin
               addr_d   = bus.base_addr_i;
               remain_d = bus.count_i;
               if (bus.count_i != '0) begin
                  state_d = ST_READ;
               end else begin
                  done_d = 1'b1;
               end
            end
         end
         ST_READ: begin
            if (issue && (remain_q == (AW+1)'(1))) begin
               state_d = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            if (occ == 2'd0) begin
               state_d = ST_IDLE;
               done_d  = 1'b1;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   assign bus.busy_o     = (state_q != ST_IDLE);
   assign bus.done_o     = done_q;
   assign bus.rd_valid_o = issue;
   assign bus.rd_addr_o  = addr_q;
   assign bus.valid_o    = (cnt_q != 2'd0);
   assign bus.data_o     = buf_q[rd_ptr_q];
endmodule

`default_nettype wire
